axis_fifo_axil_ctrl: RTL
========================

# axis_fifo_axil_ctrl

Buffers an AXI4-Stream sample stream from the acquisition fabric in an on-chip FIFO and exposes it to the PS over an AXI4-Lite slave. Register reads pop samples; status, flush, threshold and interrupt control live in the same register file. Sits between the AXI4-Stream producer (VIP in simulation) and the PS7 M_AXI_GP0 interconnect at the LPDAQ data base address.

## Interface
Parameters:
- DEPTH, 1024, FIFO depth in 32-bit words; power of two, 16..32768
- ADDR_W, 4, AXI4-Lite address bits decoded (byte address, word aligned)

Ports:
- aclk  in  1  single clock for stream, FIFO and AXI4-Lite
- aresetn  in  1  reset, asynchronous assert, active-low
- s_axis_tdata  in  32  sample word
- s_axis_tvalid  in  1  sample valid
- s_axis_tready  out  1  sample accept
- s_axis_tlast  in  1  ignored
- s_axil_awaddr  in  ADDR_W  write address
- s_axil_awvalid / s_axil_awready  in/out  1  write address handshake
- s_axil_wdata  in  32  write data
- s_axil_wstrb  in  4  ignored; full-word writes only
- s_axil_wvalid / s_axil_wready  in/out  1  write data handshake
- s_axil_bresp  out  2  always 2'b00
- s_axil_bvalid / s_axil_bready  out/in  1  write response handshake
- s_axil_araddr  in  ADDR_W  read address
- s_axil_arvalid / s_axil_arready  in/out  1  read address handshake
- s_axil_rdata  out  32  read data
- s_axil_rresp  out  2  read response
- s_axil_rvalid / s_axil_rready  out/in  1  read data handshake
- irq  out  1  level interrupt to PS

## Operation
- Register map: 0x0 DATA (RO, read pops one word); 0x4 STATUS: [15:0] level, [16] empty, [17] full, [18] overflow sticky, [19] underflow sticky; write 1 to bit 18/19 clears it; 0x8 CTRL (RW): [0] enable, [1] flush (self-clearing, reads 0), [2] irq_en; 0xC THRESH (RW) [15:0].
- Ingest: s_axis_tready = CTRL.enable. Beat with enable=1 and full=1 is dropped and sets overflow; never back-pressures while enabled.
- DATA read with FIFO empty: rdata = 0, rresp = 2'b10 (SLVERR), underflow set, level unchanged. Otherwise rresp = 2'b00 and one word popped.
- Unmapped address: read returns 0/OKAY, write ignored/OKAY.
- Level is 0..DEPTH; push and pop in the same cycle leave level unchanged; pointers wrap modulo DEPTH.
- Flush: pointers and level to 0 next cycle; beat pushed in the flush cycle is dropped (no overflow); a pop in the same cycle still returns its word; sticky bits untouched.
- irq (registered) = irq_en & ((THRESH != 0 & level >= THRESH) | overflow).

## Timing
- Reset: s_axis_tready, all ready/valid outputs, irq, rdata, rresp, bresp = 0; CTRL = 0, THRESH = 0, FIFO empty, sticky bits 0. Reset mid-transaction abandons it; no response is issued.
- Read: arready = 1 when no read outstanding. AR handshake at cycle T: pop and level decrement visible at T+1, rvalid and rdata at T+2, held until rready; next arready after R handshake. One read outstanding.
- Write: awready = wready = 1 for one cycle only when awvalid & wvalid & !bvalid; register updates and bvalid at T+1; bvalid held until bready.
- Push: accepted beat counted in level at next cycle; readable by a DATA read whose AR handshake is at least one cycle later.
- irq updates one cycle after the level/sticky/CTRL change.
- Reads and writes proceed concurrently and independently.

## Test plan
- Reset, enable=1, stream 0x1..0x8, read DATA x8 -> 0x1..0x8 in order, OKAY; then STATUS = 0x0001_0000.
- Empty read -> rdata 0, rresp 2'b10, STATUS bit 19 set; write 0x0008_0000 to STATUS -> bit 19 clears.
- DEPTH=16: push 20 words with no reads -> level 16, full, overflow set; reads return words 1..16.
- THRESH=4, irq_en=1: push 3 -> irq 0; 4th push -> irq 1 one cycle later; one read -> irq 0.
- Push 10 words, write CTRL=0x3 -> level 0, empty, CTRL reads 0x1; the next beat is stored as the only word.
- Simultaneous push and pop at level 5 -> level stays 5; enable=0 -> s_axis_tready 0 and level frozen.

Source files
------------

// File: rtl/axis_fifo_axil_ctrl_if.sv
// AXI4-Stream sink and AXI4-Lite slave signal bundle for axis_fifo_axil_ctrl.
// "slave" is the DUT view, "master" is the producer/PS view.
interface axis_fifo_axil_ctrl_if #(
  parameter int unsigned ADDR_W = 4
);
  logic [31:0]       s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;

  logic [ADDR_W-1:0] s_axil_awaddr;
  logic              s_axil_awvalid;
  logic              s_axil_awready;
  logic [31:0]       s_axil_wdata;
  logic [3:0]        s_axil_wstrb;
  logic              s_axil_wvalid;
  logic              s_axil_wready;
  logic [1:0]        s_axil_bresp;
  logic              s_axil_bvalid;
  logic              s_axil_bready;

  logic [ADDR_W-1:0] s_axil_araddr;
  logic              s_axil_arvalid;
  logic              s_axil_arready;
  logic [31:0]       s_axil_rdata;
  logic [1:0]        s_axil_rresp;
  logic              s_axil_rvalid;
  logic              s_axil_rready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    input  s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
    output s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
    input  s_axil_bready,
    input  s_axil_araddr, s_axil_arvalid, s_axil_rready,
    output s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    output s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
    input  s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
    output s_axil_bready,
    output s_axil_araddr, s_axil_arvalid, s_axil_rready,
    input  s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
  );
endinterface

// File: rtl/axis_fifo_axil_ctrl.sv
// Stream-to-register FIFO: AXI4-Stream samples are buffered and popped by AXI4-Lite DATA reads,
// with status, flush, threshold and a level interrupt in the same register file.
module axis_fifo_axil_ctrl #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axis_fifo_axil_ctrl_if.slave  bus,
  output logic                  irq
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {RegData, RegStatus, RegCtrl, RegThresh} reg_e;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   rd_word_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;

  logic        ctrl_en_q, irq_en_q, ovf_q, unf_q, irq_q;
  logic [15:0] thresh_q;

  logic        alive_q, arready_q, rd_pend_q, rd_map_q, rd_err_q;
  reg_e        rd_sel_q;
  logic        rvalid_q, bvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic [ADDR_W-1:0] awaddr, araddr;
  logic        full, empty;
  logic        ar_hs, aw_hs, wr_mapped, rd_mapped;
  reg_e        wr_sel, rd_sel;
  logic        rd_data_sel, pop, push, underflow_evt, overflow_evt, do_flush;
  logic [31:0] status_word, rd_mux;

  assign awaddr = bus.s_axil_awaddr;
  assign araddr = bus.s_axil_araddr;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  assign ar_hs     = bus.s_axil_arvalid & arready_q;
  assign aw_hs     = bus.s_axil_awvalid & bus.s_axil_wvalid & ~bvalid_q & alive_q;
  assign wr_mapped = ((awaddr >> 4) == '0);
  assign rd_mapped = ((araddr >> 4) == '0);
  assign wr_sel    = reg_e'(awaddr[3:2]);
  assign rd_sel    = reg_e'(araddr[3:2]);

  assign do_flush      = aw_hs & wr_mapped & (wr_sel == RegCtrl) & bus.s_axil_wdata[1];
  assign rd_data_sel   = ar_hs & rd_mapped & (rd_sel == RegData);
  assign pop           = rd_data_sel & ~empty;
  assign underflow_evt = rd_data_sel & empty;
  // A beat landing in the flush cycle is silently discarded, not counted as overflow.
  assign push          = bus.s_axis_tvalid & ctrl_en_q & ~full & ~do_flush;
  assign overflow_evt  = bus.s_axis_tvalid & ctrl_en_q & full & ~do_flush;

  assign status_word = {12'h000, unf_q, ovf_q, full, empty, 16'(level_q)};

  always_comb begin
    rd_mux = '0;
    if (rd_map_q) begin
      case (rd_sel_q)
        RegData:   rd_mux = rd_err_q ? 32'h0 : rd_word_q;
        RegStatus: rd_mux = status_word;
        RegCtrl:   rd_mux = {29'h0, irq_en_q, 1'b0, ctrl_en_q};
        RegThresh: rd_mux = {16'h0, thresh_q};
        default:   rd_mux = '0;
      endcase
    end
  end

  // Storage has no reset; pop captures the head word in the AR handshake cycle.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr_q] <= bus.s_axis_tdata;
    if (pop)  rd_word_q     <= mem[rd_ptr_q];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (do_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ctrl_en_q <= 1'b0;
      irq_en_q  <= 1'b0;
      thresh_q  <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      irq_q     <= 1'b0;
      bvalid_q  <= 1'b0;
      alive_q   <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (aw_hs && wr_mapped) begin
        case (wr_sel)
          RegCtrl: begin
            ctrl_en_q <= bus.s_axil_wdata[0];
            irq_en_q  <= bus.s_axil_wdata[2];
          end
          RegThresh: thresh_q <= bus.s_axil_wdata[15:0];
          default: ;
        endcase
      end
      // New events win over a same-cycle write-1-to-clear.
      if (overflow_evt) ovf_q <= 1'b1;
      else if (aw_hs && wr_mapped && wr_sel == RegStatus && bus.s_axil_wdata[18]) ovf_q <= 1'b0;
      if (underflow_evt) unf_q <= 1'b1;
      else if (aw_hs && wr_mapped && wr_sel == RegStatus && bus.s_axil_wdata[19]) unf_q <= 1'b0;
      irq_q <= irq_en_q & (((thresh_q != '0) && (17'(level_q) >= 17'(thresh_q))) | ovf_q);
      if (aw_hs) bvalid_q <= 1'b1;
      else if (bus.s_axil_bready) bvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arready_q <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_sel_q  <= RegData;
      rd_map_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      rd_pend_q <= ar_hs;
      if (ar_hs) begin
        arready_q <= 1'b0;
        rd_sel_q  <= rd_sel;
        rd_map_q  <= rd_mapped;
        rd_err_q  <= underflow_evt;
      end else if ((rvalid_q && bus.s_axil_rready) || (!alive_q)) begin
        arready_q <= 1'b1;
      end
      if (rd_pend_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
        rresp_q  <= rd_err_q ? 2'b10 : 2'b00;
      end else if (rvalid_q && bus.s_axil_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign bus.s_axis_tready  = ctrl_en_q;
  assign bus.s_axil_awready = aw_hs;
  assign bus.s_axil_wready  = aw_hs;
  assign bus.s_axil_bresp   = 2'b00;
  assign bus.s_axil_bvalid  = bvalid_q;
  assign bus.s_axil_arready = arready_q;
  assign bus.s_axil_rdata   = rdata_q;
  assign bus.s_axil_rresp   = rresp_q;
  assign bus.s_axil_rvalid  = rvalid_q;
  assign irq                = irq_q;

  logic unused_ok;
  assign unused_ok = ^{bus.s_axis_tlast, bus.s_axil_wstrb, bus.s_axil_wdata, awaddr[1:0],
                       araddr[1:0]};
endmodule
